// File: rtl/shift_frame_ctrl.sv
// shift_frame_ctrl: sequencer for a serial-in shift-register datapath.
// Takes a parallel word over valid/ready and streams it LSB first into
// the register's serial input, one bit per shift_en cycle. After WIDTH
// shifts it compares the register taps with the sent word and pulses
// frame_done with frame_ok. One frame in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   din        parallel word to serialise
//   din_valid  din is valid
//   din_ready  controller can accept a word (IDLE only)
//   flush      synchronous abort back to IDLE, no completion report
//   ser_out    serial bit to the shift register input stage
//   shift_en   shift strobe, one bit per high cycle
//   par_in     register taps, par_in[0] = stage farthest from input
//   busy       high in SHIFT, CHECK, GAP
//   frame_done one-cycle pulse on frame completion
//   frame_ok   with frame_done: taps matched the sent word
module shift_frame_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic             ser_out,
  output logic             shift_en,
  input  logic [WIDTH-1:0] par_in,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_ok
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   saved_q, saved_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               shift_en_q, shift_en_d;
  logic               ser_out_q, ser_out_d;
  logic               din_ready_q, din_ready_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_ok_q, frame_ok_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shadow_q     <= '0;
      saved_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      shift_en_q   <= 1'b0;
      ser_out_q    <= 1'b0;
      din_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      saved_q      <= saved_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      shift_en_q   <= shift_en_d;
      ser_out_q    <= ser_out_d;
      din_ready_q  <= din_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register
  // in step with it
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    saved_d      = saved_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    frame_done_d = 1'b0;
    frame_ok_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (din_valid && !flush) begin
          shadow_d = din;
          saved_d  = din;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shadow_d = shadow_q >> 1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        frame_done_d = 1'b1;
        frame_ok_d   = (par_in == saved_q);
        gap_d        = '0;
        state_d      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a completing CHECK
    if (flush) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      gap_d        = '0;
      frame_done_d = 1'b0;
      frame_ok_d   = 1'b0;
    end

    shift_en_d  = (state_d == S_SHIFT);
    ser_out_d   = shift_en_d & shadow_d[0];
    din_ready_d = (state_d == S_IDLE);
    busy_d      = ~din_ready_d;
  end

  assign shift_en   = shift_en_q;
  assign ser_out    = ser_out_q;
  assign din_ready  = din_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl: one instance with GAP_CYCLES=1 looped back
// through a 4-bit shift-register model (with optional stuck-at-0 taps),
// and one with GAP_CYCLES=0.
module tb_shift_frame_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;

  logic [W-1:0] din0, par0, m0, stuck0;
  logic         valid0, ready0, flush0, ser0, sh0, busy0, done0, ok0;

  logic [W-1:0] din1, par1, m1;
  logic         valid1, ready1, flush1, ser1, sh1, busy1, done1, ok1;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  shift_frame_ctrl #(.WIDTH(W), .GAP_CYCLES(1)) u_gap1 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(valid0), .din_ready(ready0),
    .flush(flush0), .ser_out(ser0), .shift_en(sh0), .par_in(par0),
    .busy(busy0), .frame_done(done0), .frame_ok(ok0)
  );

  shift_frame_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(valid1), .din_ready(ready1),
    .flush(flush1), .ser_out(ser1), .shift_en(sh1), .par_in(par1),
    .busy(busy1), .frame_done(done1), .frame_ok(ok1)
  );

  // Shift-register models: serial input enters at the MSB stage
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      if (sh0) m0 <= {ser0, m0[W-1:1]};
      if (sh1) m1 <= {ser1, m1[W-1:1]};
    end
  end
  assign par0 = m0 & ~stuck0;
  assign par1 = m1;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] stuck;
    logic         exp_ok;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full frame on u_gap1; entered in an IDLE cycle, leaves in the next IDLE cycle
  task automatic run_frame(input logic [W-1:0] d, input logic exp_ok);
    chk("ready_before", ready0, 1);
    din0   = d;
    valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    for (int k = 1; k <= int'(W); k++) begin
      chk("shift_en_on", sh0, 1);
      chk("ser_out_bit", ser0, d[k-1]);
      chk("ready_low", ready0, 0);
      step();
    end
    chk("check_shift_off", sh0, 0);
    chk("check_busy", busy0, 1);
    chk("check_no_done", done0, 0);
    step();
    chk("frame_done", done0, 1);
    chk("frame_ok", ok0, exp_ok);
    chk("gap_ready_low", ready0, 0);
    step();
    chk("done_cleared", done0, 0);
    chk("ok_cleared", ok0, 0);
    chk("ready_after_gap", ready0, 1);
  endtask

  vec_t vecs[8];
  int   cnt;
  logic [W-1:0] c_word;

  initial begin
    vecs[0] = '{din: 4'b1011, stuck: 4'b0000, exp_ok: 1'b1};
    vecs[1] = '{din: 4'hF,    stuck: 4'b0100, exp_ok: 1'b0};
    vecs[2] = '{din: 4'h0,    stuck: 4'b0000, exp_ok: 1'b1};
    vecs[3] = '{din: 4'h5,    stuck: 4'b0000, exp_ok: 1'b1};
    vecs[4] = '{din: 4'hA,    stuck: 4'b0000, exp_ok: 1'b1};
    vecs[5] = '{din: 4'h6,    stuck: 4'b0001, exp_ok: 1'b1};
    vecs[6] = '{din: 4'h1,    stuck: 4'b0001, exp_ok: 1'b0};
    vecs[7] = '{din: 4'h8,    stuck: 4'b1000, exp_ok: 1'b0};

    rst = 1'b1;
    din0 = '0; valid0 = 1'b0; flush0 = 1'b0; stuck0 = '0;
    din1 = '0; valid1 = 1'b0; flush1 = 1'b0;
    step();
    step();
    chk("rst_ready", ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_shift_en", sh0, 0);
    chk("rst_ser_out", ser0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ok", ok0, 0);
    rst = 1'b0;
    step();

    // Directed frames
    for (int i = 0; i < 8; i++) begin
      stuck0 = vecs[i].stuck;
      run_frame(vecs[i].din, vecs[i].exp_ok);
    end
    stuck0 = '0;

    // Async reset in the middle of SHIFT
    din0 = 4'hB; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    step();
    chk("pre_rst_shift_en", sh0, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_shift_en", sh0, 0);
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_ready", ready0, 1);
    step();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (done0) cnt++;
      step();
    end
    chk("rst_no_done", cnt, 0);

    // Back-to-back with din_valid held high: 4'h3 then 4'hC
    din0 = 4'h3; valid0 = 1'b1;
    step();
    din0 = 4'hC;
    for (int k = 1; k <= 6; k++) begin
      chk("b2b_ready_low", ready0, 0);
      chk("b2b_shift_en", sh0, (k <= 4) ? 1 : 0);
      if (k == 6) begin
        chk("b2b_done1", done0, 1);
        chk("b2b_ok1", ok0, 1);
      end
      step();
    end
    chk("b2b_ready_c7", ready0, 1);
    chk("b2b_idle_c7", sh0, 0);
    step();
    valid0 = 1'b0;
    c_word = 4'hC;
    for (int k = 1; k <= 4; k++) begin
      chk("b2b_shift2", sh0, 1);
      chk("b2b_ser2", ser0, c_word[k-1]);
      step();
    end
    step();
    chk("b2b_done2", done0, 1);
    chk("b2b_ok2", ok0, 1);
    step();
    step();

    // Flush during the second SHIFT cycle
    din0 = 4'h9; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    step();
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    chk("flush_shift_off", sh0, 0);
    chk("flush_busy", busy0, 0);
    chk("flush_ready", ready0, 1);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done0) cnt++;
      step();
    end
    chk("flush_no_done", cnt, 0);
    run_frame(4'h5, 1'b1);

    // Flush with din_valid in IDLE: no transfer
    din0 = 4'h7; valid0 = 1'b1; flush0 = 1'b1;
    step();
    valid0 = 1'b0; flush0 = 1'b0;
    chk("flush_idle_busy", busy0, 0);
    chk("flush_idle_shift", sh0, 0);

    // Flush coincident with CHECK closing edge: no report
    din0 = 4'h6; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    repeat (4) step();
    chk("flushchk_in_check", sh0, 0);
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    chk("flushchk_no_done", done0, 0);
    chk("flushchk_ready", ready0, 1);
    step();

    // GAP_CYCLES=0, all-zero word
    din1 = 4'h0; valid1 = 1'b1;
    step();
    valid1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("g0_shift_en", sh1, 1);
      chk("g0_ser_out", ser1, 0);
      step();
    end
    chk("g0_check_ser", ser1, 0);
    step();
    chk("g0_done", done1, 1);
    chk("g0_ok", ok1, 1);
    chk("g0_ready_c6", ready1, 1);
    step();
    chk("g0_done_clr", done1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
